rcounter_display: RTL and testbench
===================================

// Module: rcounter_display
// PURPOSE
//  Display-side consumer of the countdown commander outputs. Takes min/sec/10ms BCD
//  values, edit target and time-out flag; drives a 6-digit multiplexed active-low
//  7-segment display. Blinks the field being edited and flashes all digits on time-out.
//  Sits between the commander and the board pins.
// PARAMETERS
//  SCAN_DIV   100000    clk_core cycles per digit slot (>=2); 1 ms at 100 MHz
//  BLINK_DIV  25000000  clk_core cycles per blink phase (>=1); 250 ms at 100 MHz
// PORTS
//  clk_core    in   1  single system clock, rising edge
//  rst_n       in   1  asynchronous reset, active-low
//  min_i       in   8  minutes, packed BCD {tens,units}
//  sec_i       in   8  seconds, packed BCD
//  ms_10_i     in   8  10 ms units, packed BCD
//  target_i    in   2  edit field: 0 none, 1 ms_10, 2 sec, 3 min
//  time_out_i  in   1  countdown reached zero (level)
//  seg_o       out  7  segments {g,f,e,d,c,b,a}, active-low
//  dp_o        out  1  decimal point, active-low
//  an_o        out  8  digit enables, active-low; an_o[7:6] always 1
// BEHAVIOUR
//  Reset (async, rst_n=0): an_o=8'hFF, seg_o=7'h7F, dp_o=1, slot idx=0, slot cnt=0,
//   blink cnt=0, blink phase=0 (visible), shadow regs=0. All outputs registered.
//  Digit map: idx0=ms_10[3:0], idx1=ms_10[7:4], idx2=sec[3:0], idx3=sec[7:4],
//   idx4=min[3:0], idx5=min[7:4]; an_o[idx] low while driving. idx wraps 5->0.
//  Slot FSM, states ST_BLANK / ST_DRIVE:
//   ST_BLANK: 1 cycle, an_o=8'hFF, seg_o=7'h7F, dp_o=1 (anti-ghosting) -> ST_DRIVE.
//   ST_DRIVE: SCAN_DIV-1 cycles, drive digit idx; on the last one, idx++ -> ST_BLANK.
//   Reset exits into ST_BLANK, idx0.
//  Shadow capture: min/sec/ms_10/target/time_out are sampled into shadow registers
//   in the ST_BLANK cycle of idx0 only; one frame (6*SCAN_DIV cycles) is always
//   tear-free. Input changes mid-frame show from the next frame.
//  Decode: 0-9 standard active-low (0=7'h40, 1=7'h79, 5=7'h12, 9=7'h10);
//   nibble 10-15 shows dash 7'h3F.
//  dp_o=0 while driving idx2 or idx4 (separators min.sec.ms); otherwise 1.
//  Blink: free-running counter, phase toggles every BLINK_DIV cycles, independent of
//   scanning. In hidden phase (1) a suppressed digit keeps its an_o bit 1 (dp too).
//  Suppression, priority order:
//   1) shadow time_out=1: all six digits suppressed in phase 1 (whole-display flash).
//   2) else shadow target!=0: both digits of the selected field suppressed in phase 1.
//   3) else no suppression.
//  Simultaneous time_out and target!=0: time_out wins.
//  Reset mid-frame: immediate async return to reset values; no partial digit persists.
// CONFIGURATION
//  RCOUNTER_DISPLAY_LEADING_ZERO_BLANK_EN:
//   defined: idx5 (min tens) is blanked (an_o[5]=1) when its shadow nibble is 0.
//    Also blanks idx4 when min=8'h00 and target!=3. Blink/flash rules still apply
//    to visible digits.
//   undefined: all six digits always driven, zeros included.
// TESTING (bench uses SCAN_DIV=4, BLINK_DIV=64)
//  1 reset: rst_n=0 mid-drive -> same cycle an_o=FF, seg_o=7F, dp_o=1; release ->
//    first slot idx0.
//  2 scan: min=12 sec=34 ms=56, target=0 -> per 4-cycle slot: 1 blank, 3 drive.
//    Order an_o=FE/6,FD/5,FB/4,F7/3,EF/2,DF/1 (digit); dp_o=0 only on FB and EF.
//  3 edit blink: target=2 -> in phase 1 an_o bits 2,3 stay 1 while 0,1,4,5 are
//    driven. target=3 -> bits 4,5 suppressed.
//  4 time-out: time_out=1, target=1 -> phase 0 all digits shown; phase 1 an_o=FF
//    throughout.
//  5 tear/invalid: change sec_i 34->35 during idx3 -> idx2 shows 4 until next frame.
//    ms_10=8'hA0 -> idx1 shows 7'h3F.
//  6 macro: with _EN, min=05 -> an_o[5] never low. Without, idx5 shows 7'h40.

Source files
------------

// File: rtl/rcounter_display.sv
// Six-digit multiplexed active-low 7-segment driver for the countdown commander.
// Scans ms_10/sec/min BCD digits with a blank slot between digits, blinks the
// field being edited and flashes the whole display on time-out.
// Optional build macro: RCOUNTER_DISPLAY_LEADING_ZERO_BLANK_EN (blank leading minute zeros).
module rcounter_display #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 25000000
) (
    input  logic       clk_core,
    input  logic       rst_n,
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    input  logic [7:0] ms_10_i,
    input  logic [1:0] target_i,
    input  logic       time_out_i,
    output logic [6:0] seg_o,
    output logic       dp_o,
    output logic [7:0] an_o
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned BLINK_W = $clog2(BLINK_DIV + 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    logic [0:0]         state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [SCAN_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               phase_q;

    logic [7:0] min_q, sec_q, ms_10_q;
    logic [1:0] target_q;
    logic       time_out_q;

    logic [6:0] seg_d;
    logic [7:0] an_d;
    logic       dp_d;

    logic       capture_c;
    logic [3:0] nib_c;
    logic [1:0] field_c;
    logic       suppress_c;
    logic       lz_blank_c;

    // BCD nibble to active-low segments; non-decimal nibbles show a dash
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

    // Frame boundary: shadows load only in the blank slot ahead of digit 0
    assign capture_c = (state_q == ST_BLANK) && (idx_q == 3'd0);

    // Digit source nibble for the current slot
    always_comb begin
        nib_c = 4'h0;
        case (idx_q)
            3'd0:    nib_c = ms_10_q[3:0];
            3'd1:    nib_c = ms_10_q[7:4];
            3'd2:    nib_c = sec_q[3:0];
            3'd3:    nib_c = sec_q[7:4];
            3'd4:    nib_c = min_q[3:0];
            3'd5:    nib_c = min_q[7:4];
            default: nib_c = 4'h0;
        endcase
    end

    // Field owning the current digit (1 ms_10, 2 sec, 3 min) and hidden-phase suppression
    assign field_c    = 2'(idx_q[2:1]) + 2'd1;
    assign suppress_c = phase_q &&
                        (time_out_q || ((target_q != 2'd0) && (target_q == field_c)));

`ifdef RCOUNTER_DISPLAY_LEADING_ZERO_BLANK_EN
    // Hide zero minute tens, and zero minute units when minutes are 00 and not being edited
    assign lz_blank_c = ((idx_q == 3'd5) && (min_q[7:4] == 4'h0)) ||
                        ((idx_q == 3'd4) && (min_q == 8'h00) && (target_q != 2'd3));
`else
    assign lz_blank_c = 1'b0;
`endif

    // Slot state register
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            idx_q      <= 3'd0;
            slot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    // Slot next-state and pin values for the coming cycle
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        slot_cnt_d = slot_cnt_q;
        an_d       = 8'hFF;
        seg_d      = SEG_OFF;
        dp_d       = 1'b1;
        case (state_q)
            ST_BLANK: begin
                state_d    = ST_DRIVE;
                slot_cnt_d = '0;
            end
            ST_DRIVE: begin
                if (slot_cnt_q == SCAN_W'(SCAN_DIV - 2)) begin
                    state_d    = ST_BLANK;
                    slot_cnt_d = '0;
                    idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                end else begin
                    slot_cnt_d = slot_cnt_q + SCAN_W'(1);
                end
                if (!suppress_c && !lz_blank_c) begin
                    an_d[idx_q] = 1'b0;
                    seg_d       = seg_decode(nib_c);
                    dp_d        = !((idx_q == 3'd2) || (idx_q == 3'd4));
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    // Registered pin drivers
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            an_o  <= 8'hFF;
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= an_d;
            seg_o <= seg_d;
            dp_o  <= dp_d;
        end
    end

    // Frame shadow registers keep one full frame tear-free
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            ms_10_q    <= 8'h00;
            target_q   <= 2'd0;
            time_out_q <= 1'b0;
        end else if (capture_c) begin
            min_q      <= min_i;
            sec_q      <= sec_i;
            ms_10_q    <= ms_10_i;
            target_q   <= target_i;
            time_out_q <= time_out_i;
        end
    end

    // Free-running blink phase, independent of scanning
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_rcounter_display.sv
// Directed bench for rcounter_display with SCAN_DIV=4, BLINK_DIV=64.
// Output sampled 1 ns after rising edge k reflects slot cycle c = k-1 after reset
// release: slot = c/4 (pos 0 blank), digit = slot%6, blink phase = (c/64)%2.
module tb_rcounter_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, DASH = 7'h3F, OFF = 7'h7F;

    logic       clk_core = 1'b0;
    logic       rst_n;
    logic [7:0] min_i, sec_i, ms_10_i;
    logic [1:0] target_i;
    logic       time_out_i;
    logic [6:0] seg_o;
    logic       dp_o;
    logic [7:0] an_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    rcounter_display #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
        .clk_core   (clk_core),
        .rst_n      (rst_n),
        .min_i      (min_i),
        .sec_i      (sec_i),
        .ms_10_i    (ms_10_i),
        .target_i   (target_i),
        .time_out_i (time_out_i),
        .seg_o      (seg_o),
        .dp_o       (dp_o),
        .an_o       (an_o)
    );

    always #5 clk_core = ~clk_core;

    // Advance until the sampled outputs reflect slot cycle c
    task automatic adv_to(input int c);
        while (cyc < c + 1) begin
            @(posedge clk_core);
            #1;
            cyc++;
        end
    endtask

    // Compare {an_o, seg_o, dp_o} against expectations
    task automatic chk(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp);
        logic [15:0] obs, exp_v;
        obs   = {an_o, seg_o, dp_o};
        exp_v = {e_an, e_seg, e_dp};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s an/seg/dp observed %h/%h/%b expected %h/%h/%b",
                   tag, an_o, seg_o, dp_o, e_an, e_seg, e_dp);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk(tag, 8'hFF, OFF, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        min_i      = 8'h12;
        sec_i      = 8'h34;
        ms_10_i    = 8'h56;
        target_i   = 2'd0;
        time_out_i = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        chk_blank("reset_hold");
        @(negedge clk_core);
        rst_n = 1'b1;
        cyc   = 0;

        // Frame 0 (c 0-23, phase 0): scan order and separators
        adv_to(0);  chk_blank("f0_blank_idx0");
        adv_to(1);  chk("f0_idx0_first", 8'hFE, S6, 1'b1);
        adv_to(3);  chk("f0_idx0_last", 8'hFE, S6, 1'b1);
        adv_to(4);  chk_blank("f0_blank_idx1");
        adv_to(6);  chk("f0_idx1", 8'hFD, S5, 1'b1);
        adv_to(10); chk("f0_idx2", 8'hFB, S4, 1'b0);
        adv_to(14); chk("f0_idx3", 8'hF7, S3, 1'b1);
        adv_to(16); chk_blank("f0_blank_idx4");
        adv_to(18); chk("f0_idx4", 8'hEF, S2, 1'b0);
        adv_to(22); chk("f0_idx5", 8'hDF, S1, 1'b1);

        // Edit sec: captured at frame 1; phase 0 still shows it
        adv_to(23);
        target_i = 2'd2;
        adv_to(34); chk("f1_sec_visible", 8'hFB, S4, 1'b0);

        // Frame 3 (c 72-95, phase 1): sec digits hidden, others driven
        adv_to(74); chk("f3_idx0", 8'hFE, S6, 1'b1);
        adv_to(78); chk("f3_idx1", 8'hFD, S5, 1'b1);
        adv_to(82); chk_blank("f3_idx2_hidden");
        adv_to(86); chk_blank("f3_idx3_hidden");
        adv_to(90); chk("f3_idx4", 8'hEF, S2, 1'b0);
        adv_to(94); chk("f3_idx5", 8'hDF, S1, 1'b1);

        // Edit min: frame 4 (c 96-119, phase 1)
        adv_to(95);
        target_i = 2'd3;
        adv_to(106); chk("f4_idx2", 8'hFB, S4, 1'b0);
        adv_to(114); chk_blank("f4_idx4_hidden");
        adv_to(118); chk_blank("f4_idx5_hidden");

        // Time-out overrides target=1: frame 6 phase 0 shows all, frame 8 phase 1 dark
        adv_to(119);
        time_out_i = 1'b1;
        target_i   = 2'd1;
        adv_to(146); chk("f6_to_idx0", 8'hFE, S6, 1'b1);
        adv_to(150); chk("f6_to_idx1", 8'hFD, S5, 1'b1);
        adv_to(166); chk("f6_to_idx5", 8'hDF, S1, 1'b1);
        adv_to(194); chk_blank("f8_flash_idx0");
        adv_to(202); chk_blank("f8_flash_idx2");
        adv_to(210); chk_blank("f8_flash_idx4");
        adv_to(214); chk_blank("f8_flash_idx5");

        // Tear-free: inputs change during idx1 of frame 9, frame keeps old values
        adv_to(215);
        time_out_i = 1'b0;
        target_i   = 2'd0;
        adv_to(221);
        sec_i   = 8'h35;
        ms_10_i = 8'hA0;
        adv_to(226); chk("f9_idx2_old", 8'hFB, S4, 1'b0);
        adv_to(230); chk("f9_idx3_old", 8'hF7, S3, 1'b1);
        adv_to(242); chk("f10_idx0_zero", 8'hFE, S0, 1'b1);
        adv_to(246); chk("f10_idx1_dash", 8'hFD, DASH, 1'b1);
        adv_to(250); chk("f10_idx2_new", 8'hFB, S5, 1'b0);

        // Leading zero on minutes: frame 11 (c 264-287, phase 0)
        adv_to(263);
        min_i = 8'h05;
        adv_to(282); chk("f11_idx4", 8'hEF, S5, 1'b0);
        adv_to(286);
`ifdef RCOUNTER_DISPLAY_LEADING_ZERO_BLANK_EN
        chk_blank("f11_idx5_lz_blank");
`else
        chk("f11_idx5_zero", 8'hDF, S0, 1'b1);
`endif

        // Async reset mid-drive, then restart at idx0
        adv_to(290); chk("f12_idx0_pre_reset", 8'hFE, S0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_blank("async_reset");
        @(negedge clk_core);
        rst_n = 1'b1;
        cyc   = 0;
        adv_to(0); chk_blank("restart_blank");
        adv_to(2); chk("restart_idx0", 8'hFE, S0, 1'b1);
        adv_to(6); chk("restart_idx1", 8'hFD, DASH, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
